// File: rtl/fetch_ctrl_if.sv
// Fetch controller bundle: instruction-memory request/response channel,
// redirect and stall from the pipeline, and the instruction handed to decode.
interface fetch_ctrl_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_gnt;
  logic                imem_rvalid;
  logic [31:0]         imem_rdata;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                stall;
  logic                instr_valid;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one memory transaction in flight at a time,
// single-entry instruction buffer towards decode, redirect flushes in-flight data.
module fetch_ctrl #(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] WAIT = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] DROP = 3'd4;

  logic [2:0]          state_reg, state_next;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic                valid_reg, valid_next;
  logic [31:0]         instr_reg;
  logic [PC_WIDTH-1:0] instr_pc_reg;

  logic                stalled;
  logic                grant;
  logic                capture;
  logic                consume;
  logic [PC_WIDTH-1:0] redirect_target;
  logic                unused_redirect_low;

  // A buffered instruction that decode refuses blocks new requests, so a
  // response can never arrive with nowhere to put it.
  assign stalled         = valid_reg && bus.stall;
  assign bus.imem_req    = (state_reg == REQ) && !stalled;
  assign grant           = bus.imem_req && bus.imem_gnt;
  assign capture         = (state_reg == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
  assign consume         = valid_reg && !bus.stall;
  assign redirect_target = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign unused_redirect_low = &{1'b0, bus.redirect_pc[1:0]};

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (grant) begin
          state_next = WAIT;
        end else if (stalled) begin
          state_next = HOLD;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          state_next = REQ;
          pc_next    = pc_reg + PC_WIDTH'(4);
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          state_next = REQ;
        end
      end
      DROP: begin
        if (bus.imem_rvalid) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase

    // Redirect wins; if a response to the old address is still owed we must
    // sink it in DROP before issuing the next request.
    if (bus.redirect_valid) begin
      pc_next = redirect_target;
      case (state_reg)
        REQ:     state_next = grant ? DROP : REQ;
        WAIT:    state_next = bus.imem_rvalid ? REQ : DROP;
        DROP:    state_next = bus.imem_rvalid ? REQ : DROP;
        default: state_next = REQ;
      endcase
    end
  end

  always_comb begin
    valid_next = valid_reg;
    if (bus.redirect_valid) begin
      valid_next = 1'b0;
    end else if (capture) begin
      valid_next = 1'b1;
    end else if (consume) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      if (capture) begin
        instr_reg    <= bus.imem_rdata;
        instr_pc_reg <= pc_reg;
      end
    end
  end

  assign bus.imem_addr   = pc_reg;
  assign bus.instr_valid = valid_reg;
  assign bus.instr       = instr_reg;
  assign bus.instr_pc    = instr_pc_reg;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// scored against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;
  localparam int PW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.PC_WIDTH(PW)) bus ();
  fetch_ctrl_if #(.PC_WIDTH(PW)) bus2 ();

  fetch_ctrl #(.PC_WIDTH(PW), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  fetch_ctrl #(.PC_WIDTH(PW), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   delivered = 0;
  int   gnt_pct   = 100;
  int   lat_min   = 1;
  int   lat_max   = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  task automatic wait_grant(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.imem_req && bus.imem_gnt) && n < 40);
    n_checks++;
    if (!(bus.imem_req && bus.imem_gnt)) begin
      n_fail++;
      $display("FAIL %s: got no grant in 40 cycles, required a granted request", name);
    end
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // Memory for the main DUT: random grant, random response latency.
  initial begin
    logic        hs, fire;
    logic [31:0] hs_addr, raddr;
    int          cnt;
    bit          busy;
    busy = 0; cnt = 0; raddr = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      hs      = bus.imem_req && bus.imem_gnt;
      hs_addr = bus.imem_addr;
      fire    = bus.imem_rvalid;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        busy = 0; hs = 1'b0; fire = 1'b0;
      end
      if (fire) busy = 0;
      if (hs) begin
        busy  = 1;
        raddr = hs_addr;
        cnt   = $urandom_range(lat_max, lat_min);
      end
      if (busy) cnt--;
      bus.imem_rvalid = busy && (cnt == 0);
      bus.imem_rdata  = bus.imem_rvalid ? mem_word(raddr) : $urandom();
      bus.imem_gnt    = ($urandom_range(99, 0) < gnt_pct);
    end
  end

  // Memory for the wrap-around instance: always grants, answers next cycle.
  initial begin
    logic        hs2;
    logic [31:0] a2;
    bus2.imem_gnt = 1'b1; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0; bus2.stall = 1'b0;
    forever begin
      @(negedge clk);
      hs2 = bus2.imem_req && bus2.imem_gnt;
      a2  = bus2.imem_addr;
      @(posedge clk);
      #1;
      bus2.imem_rvalid = hs2 && rst_n;
      bus2.imem_rdata  = mem_word(a2);
    end
  end

  // Reference model + scoreboard monitor for the main DUT.
  initial begin
    logic [31:0] next_pc, prev_addr;
    bit          outstanding, pending_good, exp_valid, captured;
    logic        hs, rv, rd;
    logic        prev_req, prev_gnt, prev_rd, prev_valid;
    exp_t        pending, cur;
    next_pc = '0; outstanding = 0; pending_good = 0; exp_valid = 0;
    prev_req = 0; prev_gnt = 0; prev_rd = 0; prev_valid = 0; prev_addr = '0;
    pending = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        next_pc = 32'h0; outstanding = 0; pending_good = 0; exp_valid = 0;
        exp_q.delete();
        prev_req = 0; prev_gnt = 0; prev_rd = 0; prev_valid = 0;
        continue;
      end
      hs = bus.imem_req && bus.imem_gnt;
      rv = bus.imem_rvalid;
      rd = bus.redirect_valid;

      check("instr_valid", 32'(bus.instr_valid), 32'(exp_valid));
      if (bus.instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_instr: got instr_pc=%08h, required no instruction", bus.instr_pc);
        end else begin
          cur = exp_q.pop_front();
          check("instr_pc", bus.instr_pc, cur.pc);
          check("instr", bus.instr, cur.word);
          delivered++;
          $display("instr pc=%08h word=%08h", bus.instr_pc, bus.instr);
        end
      end else if (bus.instr_valid && exp_valid) begin
        check("hold_instr", bus.instr, cur.word);
        check("hold_instr_pc", bus.instr_pc, cur.pc);
      end
      if (bus.instr_valid && bus.stall) check("req_when_stalled", 32'(bus.imem_req), 32'h0);
      if (prev_req && !prev_gnt && !prev_rd && bus.imem_req)
        check("addr_stable", bus.imem_addr, prev_addr);

      captured = 0;
      if (rv) begin
        if (outstanding && pending_good && !rd) begin
          exp_q.push_back(pending);
          captured = 1;
        end
        outstanding = 0;
      end
      if (hs) begin
        check("req_while_busy", 32'(outstanding), 32'h0);
        check("fetch_addr", bus.imem_addr, next_pc);
        outstanding  = 1;
        pending_good = !rd;
        pending.pc   = next_pc;
        pending.word = mem_word(next_pc);
        next_pc      = next_pc + 32'd4;
      end
      if (rd) begin
        next_pc      = {bus.redirect_pc[31:2], 2'b00};
        pending_good = 0;
      end
      if (rd)                          exp_valid = 0;
      else if (captured)               exp_valid = 1;
      else if (exp_valid && !bus.stall) exp_valid = 0;

      prev_req = bus.imem_req; prev_gnt = bus.imem_gnt; prev_rd = rd;
      prev_valid = bus.instr_valid; prev_addr = bus.imem_addr;
    end
  end

  initial begin
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_imem_req", 32'(bus.imem_req), 32'h0);
    check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_instr_pc", bus.instr_pc, 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Back-to-back fetches, one-cycle memory: addresses 0,4,8,C.
    @(posedge clk); #2;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq_req%0d", k), 32'(bus.imem_req), 32'h1);
      check($sformatf("seq_addr%0d", k), bus.imem_addr, 32'(4 * k));
      if (k == 1) begin
        check("first_valid", 32'(bus.instr_valid), 32'h1);
        check("first_instr_pc", bus.instr_pc, 32'h0);
        check("wrap_instr_pc", bus2.instr_pc, 32'hFFFF_FFFC);
        check("wrap_instr", bus2.instr, mem_word(32'hFFFF_FFFC));
        check("wrap_next_addr", bus2.imem_addr, 32'h0);
      end
      @(posedge clk); #2;
      if (k == 0) check("first_valid_early", 32'(bus.instr_valid), 32'h0);
      @(posedge clk); #2;
    end

    // Stall right after the first instruction.
    bus.stall = 1'b1;
    reset_dut();
    repeat (3) @(posedge clk);
    #2;
    check("stall_req", 32'(bus.imem_req), 32'h0);
    check("stall_valid", 32'(bus.instr_valid), 32'h1);
    check("stall_addr", bus.imem_addr, 32'h4);
    repeat (3) begin
      @(posedge clk); #2;
      check("hold_req", 32'(bus.imem_req), 32'h0);
      check("hold_addr", bus.imem_addr, 32'h4);
    end
    @(posedge clk); #1 bus.stall = 1'b0;
    #1 check("hold_release_req", 32'(bus.imem_req), 32'h0);
    @(posedge clk); #2;
    check("resume_req", 32'(bus.imem_req), 32'h1);
    check("resume_addr", bus.imem_addr, 32'h4);

    // Redirect in WAIT without a response -> DROP, then fetch from 0x100.
    lat_min = 3; lat_max = 3;
    wait_grant("grant_drop");
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103;
    @(posedge clk); #1 bus.redirect_valid = 1'b0;
    #1 check("drop_req", 32'(bus.imem_req), 32'h0);
    for (int n = 0; n < 10 && !bus.imem_req; n++) begin
      @(posedge clk); #2;
      check("drop_valid", 32'(bus.instr_valid), 32'h0);
    end
    check("drop_next_req", 32'(bus.imem_req), 32'h1);
    check("drop_next_addr", bus.imem_addr, 32'h100);

    // Redirect coincident with a response.
    lat_min = 1; lat_max = 1;
    wait_grant("grant_coinc");
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    @(posedge clk); #1 bus.redirect_valid = 1'b0;
    #1;
    check("coinc_valid", 32'(bus.instr_valid), 32'h0);
    check("coinc_req", 32'(bus.imem_req), 32'h1);
    check("coinc_addr", bus.imem_addr, 32'h200);
    wait_grant("grant_0x200");
    repeat (2) @(posedge clk);
    #2;
    check("capture_200_pc", bus.instr_pc, 32'h200);

    // Asynchronous reset while waiting on memory.
    lat_min = 3; lat_max = 3;
    wait_grant("grant_reset");
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus.imem_req), 32'h0);
    check("async_valid", 32'(bus.instr_valid), 32'h0);
    check("async_instr", bus.instr, 32'h0);
    check("async_instr_pc", bus.instr_pc, 32'h0);
    check("async_addr", bus.imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #2;
    check("restart_req", 32'(bus.imem_req), 32'h1);
    check("restart_addr", bus.imem_addr, 32'h0);

    // Randomized traffic.
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.stall          = ($urandom_range(99, 0) < 30);
      bus.redirect_valid = ($urandom_range(99, 0) < 6);
      bus.redirect_pc    = ($urandom_range(3, 0) == 0) ?
                           (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom();
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.stall = 1'b0; bus.redirect_valid = 1'b0; gnt_pct = 100;
    repeat (20) @(posedge clk);
    #2;
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    n_checks++;
    if (delivered < 100) begin
      n_fail++;
      $display("FAIL delivered_count: got %0d, required at least 100", delivered);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of all program-counter and address signals.
REQ-002 Parameter RESET_PC, default 0: fetch address loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 imem_req  output  1  instruction-memory request valid.
REQ-006 imem_addr  output  PC_WIDTH  request address, always equal to the internal pc.
REQ-007 imem_gnt  input  1  memory accepts the request this cycle (imem_req && imem_gnt).
REQ-008 imem_rvalid  input  1  read data valid; exactly one response per granted request, earliest the cycle after grant.
REQ-009 imem_rdata  input  32  instruction word, qualified by imem_rvalid.
REQ-010 redirect_valid  input  1  branch/jump taken; overrides sequential fetch.
REQ-011 redirect_pc  input  PC_WIDTH  redirect target, qualified by redirect_valid.
REQ-012 stall  input  1  decode cannot accept the presented instruction.
REQ-013 instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-014 instr  output  32  fetched instruction word.
REQ-015 instr_pc  output  PC_WIDTH  address the instruction was fetched from.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, HOLD, DROP; exactly one active.
REQ-017 IDLE: imem_req=0; unconditionally REQ next cycle.
REQ-018 REQ: imem_req=1; on imem_gnt go WAIT; else stay with imem_addr unchanged.
REQ-019 WAIT: imem_req=0; on imem_rvalid capture instr=imem_rdata, instr_pc=pc, set instr_valid, pc<=pc+4, go REQ.
REQ-020 A presented instruction is consumed in any cycle where instr_valid=1 and stall=0; instr_valid clears next cycle unless a new instruction is captured the same cycle.
REQ-021 If instr_valid=1 and stall=1 when a response arrives in WAIT, the response is still captured only if the current one is consumed; otherwise response is held is not permitted: controller SHALL not issue a request (stay in HOLD) while instr_valid=1 and stall=1.
REQ-022 HOLD: entered from REQ (before asserting imem_req) when instr_valid=1 and stall=1; imem_req=0; return to REQ when stall=0.
REQ-023 pc+4 is modulo 2^PC_WIDTH; PC_WIDTH'(2^PC_WIDTH-4)+4 wraps to 0.
REQ-024 redirect_pc bits [1:0] are forced to 0 when loaded into pc.
REQ-025 redirect_valid has priority over every other event in the same cycle: pc<=redirect_pc, instr_valid<=0, stall ignored.
REQ-026 Redirect in IDLE, REQ without gnt, HOLD, or WAIT with imem_rvalid the same cycle: next state REQ; any same-cycle response is discarded.
REQ-027 Redirect in REQ with imem_gnt, or in WAIT without imem_rvalid: next state DROP (one response outstanding to old address).
REQ-028 DROP: imem_req=0; on imem_rvalid discard data, go REQ; a further redirect in DROP updates pc and stays in DROP unless rvalid the same cycle (then REQ).
REQ-029 imem_req is never asserted while a response is outstanding (at most one transaction in flight).

Reset
REQ-030 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0; effective immediately, without a clock edge.
REQ-031 Reset asserted mid-transaction abandons it; a response arriving after release in IDLE/REQ is ignored only if the memory was also reset (system requirement).

Verification
REQ-032 Release reset, gnt=1, rvalid one cycle later each time -> imem_addr sequence 0,4,8,C; instr_pc matches; first instr_valid 3 cycles after release.
REQ-033 stall=1 after first instruction at 0x0 -> instr holds, imem_req=0 (HOLD), no pc change; stall=0 -> request to 0x4 next cycle.
REQ-034 Redirect to 0x103 in WAIT without rvalid -> DROP; old response discarded, instr_valid=0; next request address 0x100.
REQ-035 Redirect coincident with rvalid in WAIT -> data discarded, next state REQ, imem_addr=redirect target.
REQ-036 RESET_PC=0xFFFFFFFC, one fetch -> instr_pc=0xFFFFFFFC, next imem_addr=0x0.
REQ-037 Assert rst_n=0 in WAIT between edges -> imem_req=0, instr_valid=0 immediately; fetch restarts from RESET_PC.
